// File: rtl/tetris_pkg.sv
// tetris_pkg: definitions shared by the board store and the colour generator.
//   - block codes (0 = empty cell)
//   - sweep FSM state encoding
//   - board geometry defaults (cells and pixel origin)
//   - block colour palette and code_to_color lookup
package tetris_pkg;

  localparam int BOARD_COLS  = 10;
  localparam int BOARD_ROWS  = 20;
  localparam int BOARD_ORG_X = 220;
  localparam int BOARD_ORG_Y = 40;
  localparam int BOARD_CELL  = 20;

  typedef enum logic [2:0] {
    BLK_EMPTY = 3'd0,
    BLK_T     = 3'd1,
    BLK_O     = 3'd2,
    BLK_L     = 3'd3,
    BLK_J     = 3'd4,
    BLK_S     = 3'd5,
    BLK_Z     = 3'd6,
    BLK_I     = 3'd7
  } block_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_SCAN,
    ST_SHIFT,
    ST_FIN
  } state_e;

  localparam logic [23:0] COL_BLUE        = 24'h66B2FF;
  localparam logic [23:0] COL_PINK        = 24'hFF3399;
  localparam logic [23:0] COL_DARK_PURPLE = 24'h7F00FF;
  localparam logic [23:0] COL_YELLOW      = 24'hFFFF66;
  localparam logic [23:0] COL_GREEN       = 24'h66FF66;
  localparam logic [23:0] COL_PLUM        = 24'h990099;
  localparam logic [23:0] COL_MINTY       = 24'h99FFCC;

  function automatic logic [23:0] code_to_color(input logic [2:0] code);
    logic [23:0] c;
    case (code)
      BLK_T:   c = COL_BLUE;
      BLK_O:   c = COL_PINK;
      BLK_L:   c = COL_DARK_PURPLE;
      BLK_J:   c = COL_YELLOW;
      BLK_S:   c = COL_GREEN;
      BLK_Z:   c = COL_PLUM;
      BLK_I:   c = COL_MINTY;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/board_memory_pix_to_cell.sv
// pix_to_cell: maps a pixel (row, column) to a board cell.
//   row, column : current pixel position
//   in_board    : pixel lies inside the board rectangle
//   cx, cy      : cell coordinates (only meaningful when in_board)
// Cell index is found by counting how many cell boundaries the offset has
// passed, so no divider is needed.
module pix_to_cell
  import tetris_pkg::*;
#(
  parameter int COLS  = BOARD_COLS,
  parameter int ROWS  = BOARD_ROWS,
  parameter int ORG_X = BOARD_ORG_X,
  parameter int ORG_Y = BOARD_ORG_Y,
  parameter int CELL  = BOARD_CELL
) (
  input  logic [8:0] row,
  input  logic [9:0] column,
  output logic       in_board,
  output logic [3:0] cx,
  output logic [4:0] cy
);

  localparam logic [9:0] X_LO = 10'(ORG_X);
  localparam logic [9:0] X_HI = 10'(ORG_X + COLS * CELL);
  localparam logic [8:0] Y_LO = 9'(ORG_Y);
  localparam logic [8:0] Y_HI = 9'(ORG_Y + ROWS * CELL);

  logic [9:0] dx;
  logic [8:0] dy;

  always_comb begin
    in_board = (column >= X_LO) && (column < X_HI) && (row >= Y_LO) && (row < Y_HI);
    // Offsets wrap when outside the board; the result is then gated by in_board.
    dx = column - X_LO;
    dy = row - Y_LO;
    cx = '0;
    cy = '0;
    for (int k = 1; k < COLS; k++) begin
      if (dx >= 10'(k * CELL)) cx = cx + 4'd1;
    end
    for (int k = 1; k < ROWS; k++) begin
      if (dy >= 9'(k * CELL)) cy = cy + 5'd1;
    end
  end

endmodule

// File: rtl/board_memory.sv
// board_memory: 10x20 Tetris playfield store with lock write, collision
// query and line-clear sweep.
//   clk, rst               : clock, synchronous active-high reset
//   clear_all              : wipe the board and abort any sweep
//   row, column            : pixel position -> ram_color (combinational)
//   lock_req/lock_block/xs/ys : write four squares, then sweep full rows
//   query_xs/ys -> query_hit  : combinational collision test of four squares
//   busy, done, lines_cleared, top_out : sweep status
module board_memory
  import tetris_pkg::*;
#(
  parameter int COLS  = BOARD_COLS,
  parameter int ROWS  = BOARD_ROWS,
  parameter int ORG_X = BOARD_ORG_X,
  parameter int ORG_Y = BOARD_ORG_Y,
  parameter int CELL  = BOARD_CELL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_all,
  input  logic [8:0]  row,
  input  logic [9:0]  column,
  output logic [23:0] ram_color,
  input  logic        lock_req,
  input  logic [2:0]  lock_block,
  input  logic [15:0] lock_xs,
  input  logic [19:0] lock_ys,
  input  logic [15:0] query_xs,
  input  logic [19:0] query_ys,
  output logic        query_hit,
  output logic        busy,
  output logic        done,
  output logic [2:0]  lines_cleared,
  output logic        top_out
);

  localparam logic [3:0] MAX_X = 4'(COLS - 1);
  localparam logic [4:0] MAX_Y = 5'(ROWS - 1);

  logic [2:0]  cells_q [ROWS][COLS];
  logic [2:0]  cells_d [ROWS][COLS];
  state_e      state_q, state_d;
  logic [2:0]  blk_q, blk_d;
  logic [15:0] xs_q, xs_d;
  logic [19:0] ys_q, ys_d;
  logic [4:0]  r_q, r_d;
  logic [4:0]  s_q, s_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  lines_q, lines_d;
  logic        top_q, top_d;

  logic        row_full;
  logic        row0_any;
  logic        in_board;
  logic [3:0]  pcx;
  logic [4:0]  pcy;

  // Pixel side
  pix_to_cell #(
    .COLS (COLS),
    .ROWS (ROWS),
    .ORG_X(ORG_X),
    .ORG_Y(ORG_Y),
    .CELL (CELL)
  ) u_pix_to_cell (
    .row     (row),
    .column  (column),
    .in_board(in_board),
    .cx      (pcx),
    .cy      (pcy)
  );

  assign ram_color = in_board ? code_to_color(cells_q[pcy][pcx]) : 24'h000000;

  // Collision query: range is checked before the array is indexed.
  always_comb begin
    logic [3:0] qx;
    logic [4:0] qy;
    query_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      qx = query_xs[4*k +: 4];
      qy = query_ys[5*k +: 5];
      if (qx > MAX_X || qy > MAX_Y) query_hit = 1'b1;
      else if (cells_q[qy][qx] != 3'd0) query_hit = 1'b1;
    end
  end

  always_comb begin
    row_full = 1'b1;
    row0_any = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (cells_q[r_q][c] == 3'd0) row_full = 1'b0;
      if (cells_q[0][c] != 3'd0) row0_any = 1'b1;
    end
  end

  // Sweep FSM
  always_comb begin
    logic [3:0] lx;
    logic [4:0] ly;
    state_d = state_q;
    cells_d = cells_q;
    blk_d   = blk_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    top_d   = top_q;
    lx      = '0;
    ly      = '0;

    case (state_q)
      ST_IDLE: begin
        if (lock_req) begin
          blk_d   = lock_block;
          xs_d    = lock_xs;
          ys_d    = lock_ys;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        for (int k = 0; k < 4; k++) begin
          lx = xs_q[4*k +: 4];
          ly = ys_q[5*k +: 5];
          if (lx <= MAX_X && ly <= MAX_Y) cells_d[ly][lx] = blk_q;
        end
        r_d     = MAX_Y;
        cnt_d   = 3'd0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (row_full) begin
          if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
          s_d     = r_q;
          state_d = ST_SHIFT;
        end else if (r_q == 5'd0) begin
          state_d = ST_FIN;
        end else begin
          r_d = r_q - 5'd1;
        end
      end
      ST_SHIFT: begin
        if (s_q != 5'd0) cells_d[s_q] = cells_q[s_q - 5'd1];
        // The copy into row 1 is the last one; row 0 empties in the same cycle.
        if (s_q <= 5'd1) begin
          for (int c = 0; c < COLS; c++) cells_d[0][c] = 3'd0;
          state_d = ST_SCAN;
        end else begin
          s_d = s_q - 5'd1;
        end
      end
      ST_FIN: begin
        lines_d = cnt_q;
        top_d   = row0_any;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_all) begin
      for (int y = 0; y < ROWS; y++)
        for (int c = 0; c < COLS; c++) cells_d[y][c] = 3'd0;
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      lines_d = 3'd0;
      top_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      top_q   <= 1'b0;
      for (int y = 0; y < ROWS; y++)
        for (int c = 0; c < COLS; c++) cells_q[y][c] <= 3'd0;
    end else begin
      state_q <= state_d;
      cells_q <= cells_d;
      blk_q   <= blk_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      top_q   <= top_d;
    end
  end

  // Results are presented during FIN together with done, then held.
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FIN);
  assign lines_cleared = (state_q == ST_FIN) ? cnt_q : lines_q;
  assign top_out       = (state_q == ST_FIN) ? row0_any : top_q;

endmodule
